// File: rtl/accel_pkg.sv
// Shared types for the job scheduler: field widths, FSM states and the queued job record.
package accel_pkg;

   localparam int WIDTH_W = 9;
   localparam int ITER_W  = 16;
   localparam int PEND_W  = 5;
   localparam int GAP_W   = 4;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      RUN,
      GAP
   } sched_state_t;

   typedef struct packed {
      logic [WIDTH_W-1:0] width;
      logic [ITER_W-1:0]  iter;
   } job_t;

   // A job with no columns or no iterations has nothing for the Controller to do.
   function automatic logic job_is_valid(input job_t job);
      return (job.width != '0) && (job.iter != '0);
   endfunction

endpackage

// File: rtl/sched_fifo.sv
// Synchronous FIFO of job records with occupancy count and a single-cycle flush.
module sched_fifo
   import accel_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  job_t                   i_data,
   input  logic                   i_pop,
   input  logic                   i_flush,
   output job_t                   o_head,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);

   job_t          r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full && !i_flush;
   assign w_do_pop  = i_pop && !o_empty && !i_flush;

   // NOTE: storage is deliberately not reset; r_count alone says which entries are meaningful.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // Pointers are power-of-two wide, so the increment wraps on its own.
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/job_scheduler.sv
// Queues matrix-vector jobs and sequences them onto the Controller with a forced idle gap.
// Define JOB_SCHED_PERF_EN to add the last_cycles / total_jobs performance outputs.
module job_scheduler
   import accel_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [WIDTH_W-1:0] cmd_width,
   input  logic [ITER_W-1:0]  cmd_iter,
   input  logic               abort,
   output logic               running,
   output logic [WIDTH_W-1:0] width,
   output logic [ITER_W-1:0]  iteration,
   input  logic               finish,
   output logic               busy,
   output logic               job_done,
   output logic               job_err,
   output logic [PEND_W-1:0]  pending
`ifdef JOB_SCHED_PERF_EN
   ,
   output logic [31:0]        last_cycles,
   output logic [15:0]        total_jobs
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   sched_state_t       r_state;
   sched_state_t       w_state_nxt;
   logic [WIDTH_W-1:0] r_width;
   logic [ITER_W-1:0]  r_iter;
   logic [GAP_W-1:0]   r_gap_cnt;
   logic               r_job_done;
   logic               r_job_err;

   job_t               w_head;
   job_t               w_cmd_job;
   logic               w_full;
   logic               w_empty;
   logic [CNT_W-1:0]   w_count;
   logic               w_push;
   logic               w_pop;
   logic               w_load;
   logic               w_err;
   logic               w_done;
   logic               w_gap_load;

   assign w_cmd_job = '{width: cmd_width, iter: cmd_iter};
   assign cmd_ready = !w_full && !abort;
   assign w_push    = cmd_valid && cmd_ready;

   sched_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_cmd_job),
      .i_pop   (w_pop),
      .i_flush (abort),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_load      = 1'b0;
      w_err       = 1'b0;
      w_done      = 1'b0;
      w_gap_load  = 1'b0;
      if (abort) begin
         w_gap_load  = 1'b1;
         w_state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  w_pop = 1'b1;
                  if (job_is_valid(w_head)) begin
                     w_load      = 1'b1;
                     w_state_nxt = LAUNCH;
                  end else begin
                     w_err = 1'b1;
                  end
               end
            end
            LAUNCH: w_state_nxt = RUN;
            RUN: begin
               if (finish) begin
                  w_done      = 1'b1;
                  w_gap_load  = 1'b1;
                  w_state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
               end
            end
            GAP: begin
               if (r_gap_cnt <= GAP_W'(1)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_width    <= '0;
         r_iter     <= '0;
         r_gap_cnt  <= '0;
         r_job_done <= 1'b0;
         r_job_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_job_done <= w_done;
         r_job_err  <= w_err;
         // Loaded only on dispatch from IDLE, so the job fields are frozen throughout RUN.
         if (w_load) begin
            r_width <= w_head.width;
            r_iter  <= w_head.iter;
         end
         if (w_gap_load) begin
            r_gap_cnt <= GAP_W'(GAP_CYCLES);
         end else if (r_state == GAP && r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
         end
      end
   end

   // Abort must kill running within the cycle it is raised, ahead of the state update.
   assign running   = (r_state == RUN) && !abort;
   assign width     = r_width;
   assign iteration = r_iter;
   assign job_done  = r_job_done;
   assign job_err   = r_job_err;
   assign pending   = PEND_W'(w_count);
   assign busy      = (r_state != IDLE) || (w_count != '0);

`ifdef JOB_SCHED_PERF_EN
   logic [31:0] r_run_cnt;
   logic [31:0] r_last_cycles;
   logic [15:0] r_total_jobs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run_cnt     <= '0;
         r_last_cycles <= '0;
         r_total_jobs  <= '0;
      end else begin
         if (r_state == LAUNCH)   r_run_cnt <= '0;
         else if (r_state == RUN) r_run_cnt <= r_run_cnt + 32'd1;
         // The finishing cycle itself is a RUN cycle, hence the +1.
         if (w_done) begin
            r_last_cycles <= r_run_cnt + 32'd1;
            r_total_jobs  <= r_total_jobs + 16'd1;
         end
      end
   end

   assign last_cycles = r_last_cycles;
   assign total_jobs  = r_total_jobs;
`endif

endmodule

// File: doc/job_scheduler.md
JOB_SCHEDULER -- requirements
Module: job_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of queued jobs (power of two, 2..16).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle cycles forced between consecutive jobs (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have ports cmd_valid input 1, cmd_ready output 1: job-submit handshake.
REQ-006 SHALL have ports cmd_width input 9 and cmd_iter input 16: job row width and iteration count.
REQ-007 SHALL have port abort  input  1  single-cycle request to kill the current job and flush the queue.
REQ-008 SHALL have ports running output 1, width output 9, iteration output 16: drive the matrix-vector Controller.
REQ-009 SHALL have port finish  input  1  Controller end-of-job pulse.
REQ-010 SHALL have ports busy output 1, job_done output 1 (pulse), job_err output 1 (pulse), pending output 5 (queued job count).

Function
REQ-011 SHALL accept a job when cmd_valid && cmd_ready; cmd_ready = !fifo_full && !abort.
REQ-012 SHALL check jobs at dispatch: width==0 or iter==0 pops the job, pulses job_err for 1 cycle, and never asserts running.
REQ-013 SHALL use FSM states IDLE, LAUNCH, RUN, GAP.
REQ-014 IDLE: FIFO non-empty -> LAUNCH; width/iteration register the FIFO head; entry popped.
REQ-015 LAUNCH: running=1 from the next cycle; -> RUN. width/iteration SHALL stay stable whenever running=1.
REQ-016 RUN: running held at 1 until finish is sampled; running=0 the cycle after finish; job_done pulses that same cycle; -> GAP.
REQ-017 GAP: counts GAP_CYCLES cycles with running=0; at 0 -> IDLE; GAP_CYCLES=0 goes straight to IDLE.
REQ-018 Minimum finish-to-next-running spacing SHALL be GAP_CYCLES+2 cycles.
REQ-019 finish outside RUN SHALL be ignored.
REQ-020 abort SHALL in the same cycle deassert running, flush the FIFO (pending=0) and move to GAP; no job_done; a simultaneous cmd_valid is dropped (cmd_ready=0).
REQ-021 abort together with finish: abort wins and job_done is suppressed.
REQ-022 Push and pop in the same cycle with a full FIFO SHALL be refused (cmd_ready=0); with a non-full FIFO both occur and pending is unchanged.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; pending ranges 0..FIFO_DEPTH.
REQ-024 busy = (state!=IDLE) || pending!=0.

Reset
REQ-025 SHALL apply asynchronous active-high reset: state=IDLE, running=0, width=0, iteration=0, pending=0, job_done=0, job_err=0, cmd_ready=1 after release, gap counter=0.
REQ-026 Reset mid-RUN SHALL drop running immediately and discard all queued jobs.

Configuration
REQ-027 With JOB_SCHED_PERF_EN defined, SHALL add outputs last_cycles (32 bits, RUN cycles of the last completed job, latched on job_done) and total_jobs (16 bits, wrapping, counts job_done); both reset to 0.
REQ-028 Without JOB_SCHED_PERF_EN, these ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package accel_pkg SHALL hold WIDTH_W=9, ITER_W=16, the FSM state enum and the job record typedef (width, iter).
REQ-030 SHALL instantiate one sub-module sched_fifo (synchronous FIFO of job records, FIFO_DEPTH entries, full/empty/count).

Verification
REQ-031 Push job (13,1), finish 20 cycles after running rises -> running high for exactly 20 cycles, one job_done, busy low after GAP.
REQ-032 Push (28,1),(30,2),(13,1) back-to-back -> three runs in order, width/iteration exact per run, running low for >= GAP_CYCLES+1 cycles between runs.
REQ-033 Push FIFO_DEPTH+1 jobs while the first is running -> cmd_ready low on the extra push, pending=FIFO_DEPTH, no job lost.
REQ-034 Push (0,5) then (13,1) -> job_err pulse, no running for the first, second runs normally.
REQ-035 abort mid-RUN with 2 queued -> running=0 the same cycle, pending=0, no job_done, finish arriving later ignored.
REQ-036 Reset asserted mid-RUN -> all outputs at reset values asynchronously; PERF build: last_cycles=20 and total_jobs=1 after scenario REQ-031.
